conv_stream_driver: RTL and testbench

Transmit/collect counterpart to conv_8_4. A host loads an 8-entry x vector and a 4-entry f vector into local register buffers. On start, the block acts as master on the x and f valid/ready streams feeding conv_8_4 and as slave on the y result stream. It buffers the 5 results for host readback and flags done.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/stream_tx_chan.sv | 71 +++++++
 rtl/conv_stream_driver.sv | 158 +++++++++++++++
 tb/tb_conv_stream_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, vector lengths and run states for conv_stream_driver
package conv_pkg;

  // sample and result widths (signed two's complement)
  localparam int XW = 8;
  localparam int YW = 18;

  // vector lengths; NY is the number of valid-mode convolution outputs
  localparam int NX = 8;
  localparam int NF = 4;
  localparam int NY = NX - NF + 1;

  // counter width: must hold NX, NF and NY without wrapping
  localparam int CW = 4;

  // buffer address widths for the x and f load ports
  localparam int XAW = 3;
  localparam int FAW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_t;

endpackage

// File: rtl/stream_tx_chan.sv
// rtl/stream_tx_chan.sv - one buffered valid/ready master channel that replays an N-entry vector
module stream_tx_chan #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_ld_en,
  input  logic [LOGN-1:0] i_ld_addr,
  input  logic [W-1:0]    i_ld_data,
  input  logic            i_arm,
  input  logic            i_abort,
  output logic [W-1:0]    o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_finished
);

  logic [W-1:0]  r_buf [N];
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic [W-1:0]  r_data;

  logic          w_xfer;
  logic [CW-1:0] w_cnt_inc;
  logic [W-1:0]  w_first;

  assign w_xfer    = r_valid & i_ready;
  assign w_cnt_inc = r_cnt + CW'(1);

  // a load of entry 0 on the arming edge must be the value that goes out first
  assign w_first = (i_ld_en && (i_ld_addr == '0)) ? i_ld_data : r_buf[0];

  // high when every entry has been delivered, counting a transfer at the coming edge
  assign o_finished = (r_cnt == CW'(N)) || (w_xfer && (w_cnt_inc == CW'(N)));

  assign o_data  = r_data;
  assign o_valid = r_valid;

  // host write port into the local vector buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      r_buf[i_ld_addr] <= i_ld_data;
    end
  end

  // stream engine: valid and data are registered and only move on a completed transfer
  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_arm) begin
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_data  <= w_first;
    end else if (w_xfer) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc < CW'(N)) begin
        r_valid <= 1'b1;
        r_data  <= r_buf[w_cnt_inc[LOGN-1:0]];
      end else begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - feeds x/f vectors to conv_8_4 and collects its y results
module conv_stream_driver
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_en,
  input  logic          ld_sel,
  input  logic [2:0]    ld_addr,
  input  logic [XW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] m_data_x,
  output logic          m_valid_x,
  input  logic          m_ready_x,
  output logic [XW-1:0] m_data_f,
  output logic          m_valid_f,
  input  logic          m_ready_f,
  input  logic [YW-1:0] s_data_y,
  input  logic          s_valid_y,
  output logic          s_ready_y,
  input  logic [2:0]    rd_addr,
  output logic [YW-1:0] rd_data
);

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_y_cnt;
  logic [YW-1:0] r_ybuf [NY];

  logic          w_idle;
  logic          w_start;
  logic          w_ld_x;
  logic          w_ld_f;
  logic          w_abort;
  logic          w_x_fin;
  logic          w_f_fin;
  logic          w_y_acc;
  logic [CW-1:0] w_y_cnt_inc;
  logic          w_y_fin;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle & start;
  assign w_ld_x  = w_idle & ld_en & ~ld_sel;
  assign w_ld_f  = w_idle & ld_en & ld_sel;

  // park both channels once a run has completed
  assign w_abort = (r_state == FIN);

  assign s_ready_y   = (r_state == STREAM) && (r_y_cnt < CW'(NY));
  assign w_y_acc     = s_valid_y & s_ready_y;
  assign w_y_cnt_inc = r_y_cnt + CW'(1);
  assign w_y_fin     = (r_y_cnt == CW'(NY)) || (w_y_acc && (w_y_cnt_inc == CW'(NY)));

  assign busy = r_busy;
  assign done = r_done;

  stream_tx_chan #(
    .W    (XW),
    .N    (NX),
    .LOGN (XAW),
    .CW   (CW)
  ) u_x_chan (
    .clk        (clk),
    .reset      (reset),
    .i_ld_en    (w_ld_x),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .i_arm      (w_start),
    .i_abort    (w_abort),
    .o_data     (m_data_x),
    .o_valid    (m_valid_x),
    .i_ready    (m_ready_x),
    .o_finished (w_x_fin)
  );

  stream_tx_chan #(
    .W    (XW),
    .N    (NF),
    .LOGN (FAW),
    .CW   (CW)
  ) u_f_chan (
    .clk        (clk),
    .reset      (reset),
    .i_ld_en    (w_ld_f),
    .i_ld_addr  (ld_addr[FAW-1:0]),
    .i_ld_data  (ld_data),
    .i_arm      (w_start),
    .i_abort    (w_abort),
    .o_data     (m_data_f),
    .o_valid    (m_valid_f),
    .i_ready    (m_ready_f),
    .o_finished (w_f_fin)
  );

  // run sequencer: FIN is entered on the edge that completes the last of the three streams
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            r_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_x_fin && w_f_fin && w_y_fin) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // result capture: cleared at the start of every run, filled in arrival order
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_y_cnt <= '0;
      for (int i = 0; i < NY; i++) begin
        r_ybuf[i] <= '0;
      end
    end else if (w_y_acc) begin
      r_y_cnt <= w_y_cnt_inc;
      for (int i = 0; i < NY; i++) begin
        if (r_y_cnt == CW'(i)) begin
          r_ybuf[i] <= s_data_y;
        end
      end
    end
  end

  // host readback mux; out-of-range addresses read as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NY; i++) begin
      if (rd_addr == 3'(i)) begin
        rd_data = r_ybuf[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - randomized loopback bench for conv_stream_driver
module tb_conv_stream_driver;
  import conv_pkg::*;

  logic          clk;
  logic          reset;
  logic          ld_en;
  logic          ld_sel;
  logic [2:0]    ld_addr;
  logic [XW-1:0] ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [XW-1:0] m_data_x;
  logic          m_valid_x;
  logic          m_ready_x;
  logic [XW-1:0] m_data_f;
  logic          m_valid_f;
  logic          m_ready_f;
  logic [YW-1:0] s_data_y;
  logic          s_valid_y;
  logic          s_ready_y;
  logic [2:0]    rd_addr;
  logic [YW-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  int mx [NX];
  int mf [NF];

  conv_stream_driver dut (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .m_data_x  (m_data_x),
    .m_valid_x (m_valid_x),
    .m_ready_x (m_ready_x),
    .m_data_f  (m_data_f),
    .m_valid_f (m_valid_f),
    .m_ready_f (m_ready_f),
    .s_data_y  (s_data_y),
    .s_valid_y (s_valid_y),
    .s_ready_y (s_ready_y),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int conv_ref(input int k);
    int s = 0;
    for (int j = 0; j < NF; j++) s += mx[k + j] * mf[j];
    return s;
  endfunction

  task automatic load_one(input bit sel, input int addr, input int val);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = addr[2:0];
    ld_data = val[XW-1:0];
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_vectors(input int xv [NX], input int fv [NF]);
    for (int i = 0; i < NX; i++) begin
      load_one(1'b0, i, xv[i]);
      mx[i] = xv[i];
    end
    for (int i = 0; i < NF; i++) begin
      load_one(1'b1, i, fv[i]);
      mf[i] = fv[i];
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), $signed(rd_data), (i < NY) ? conv_ref(i) : 0);
    end
    @(negedge clk);
  endtask

  // One full run against a behavioural conv_8_4 stand-in with random handshakes.
  // x_hold: cycles with x ready forced low (f ready forced high meanwhile).
  // inject_at: cycle at which start and an x[0] load are pulsed mid-run (-1 = never).
  task automatic run_loop(input string tag, input int x_hold, input int inject_at);
    int xq [$];
    int fq [$];
    int yq [$];
    bit built = 0;
    int done_cnt = 0;
    int done_at = -1;
    int last_y = -1;
    int ytmp;
    int s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_valid_x_lat"}, m_valid_x, 1);
    check({tag, "_valid_f_lat"}, m_valid_f, 1);
    check({tag, "_busy"}, busy, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 4) break;
      if (cyc < x_hold) begin
        check({tag, "_hold_vx"}, m_valid_x, 1);
        check({tag, "_hold_dx"}, $signed(m_data_x), mx[0]);
      end
      if (x_hold > 0 && cyc == x_hold) check({tag, "_f_indep"}, fq.size(), NF);
      start = 1'b0;
      ld_en = 1'b0;
      if (cyc == inject_at) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = 3'd0;
        ld_data = 8'd99;
      end
      m_ready_x = (cyc < x_hold) ? 1'b0 : ($urandom_range(0, 1) == 1);
      m_ready_f = (cyc < x_hold) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (m_valid_x && m_ready_x) xq.push_back($signed(m_data_x));
      if (m_valid_f && m_ready_f) fq.push_back($signed(m_data_f));
      s_valid_y = 1'b0;
      if (yq.size() > 0) begin
        ytmp      = yq[0];
        s_data_y  = ytmp[YW-1:0];
        s_valid_y = ($urandom_range(0, 1) == 1);
        if (s_valid_y && s_ready_y) begin
          void'(yq.pop_front());
          if (yq.size() == 0) last_y = cyc;
        end
      end
      if (!built && xq.size() == NX && fq.size() == NF) begin
        built = 1;
        for (int k = 0; k < NY; k++) begin
          s = 0;
          for (int j = 0; j < NF; j++) s += xq[k + j] * fq[j];
          yq.push_back(s);
        end
      end
      @(negedge clk);
    end
    m_ready_x = 1'b0;
    m_ready_f = 1'b0;
    s_valid_y = 1'b0;
    start     = 1'b0;
    ld_en     = 1'b0;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_lat"}, done_at, last_y + 1);
    check({tag, "_nx"}, xq.size(), NX);
    check({tag, "_nf"}, fq.size(), NF);
    for (int i = 0; i < NX; i++) check($sformatf("%s_x%0d", tag, i), (i < xq.size()) ? xq[i] : -999, mx[i]);
    for (int i = 0; i < NF; i++) check($sformatf("%s_f%0d", tag, i), (i < fq.size()) ? fq[i] : -999, mf[i]);
    check({tag, "_idle_busy"}, busy, 0);
    check_results(tag);
  endtask

  initial begin
    int xv [NX];
    int fv [NF];
    int xfers;
    bit got_done;

    reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; m_ready_x = 1'b0; m_ready_f = 1'b0;
    s_data_y = '0; s_valid_y = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vx", m_valid_x, 0);
    check("rst_vf", m_valid_f, 0);
    check("rst_dx", m_data_x, 0);
    check("rst_df", m_data_f, 0);
    check("rst_ry", s_ready_y, 0);
    s_valid_y = 1'b1; s_data_y = 18'd55;
    #1;
    check("idle_ry", s_ready_y, 0);
    @(negedge clk);
    s_valid_y = 1'b0;
    for (int i = 0; i < NY; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("rst_rd%0d", i), rd_data, 0);
    end
    @(negedge clk);

    // 1: reference vectors, random handshakes
    xv = '{10, -20, 30, -40, 50, 60, 70, 80};
    fv = '{10, 20, -30, 40};
    load_vectors(xv, fv);
    check("ref_y0", conv_ref(0), -2800);
    run_loop("t1", 0, -1);

    // 2: x ready held low for 10 cycles
    run_loop("t2", 10, -1);

    // 3: seven back-to-back y beats, only five accepted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      s_valid_y = 1'b1;
      s_data_y  = 18'(k);
      check($sformatf("t3_ry%0d", k), s_ready_y, (k <= NY) ? 1 : 0);
      @(negedge clk);
    end
    s_valid_y = 1'b0;
    m_ready_x = 1'b1;
    m_ready_f = 1'b1;
    got_done = 0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      if (done) got_done = 1;
      else @(negedge clk);
    end
    check("t3_done", got_done, 1);
    m_ready_x = 1'b0;
    m_ready_f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      check($sformatf("t3_rd%0d", i), rd_data, (i < NY) ? i + 1 : 0);
    end
    repeat (2) @(negedge clk);

    // 4: reset after three x transfers
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_ready_x = 1'b1;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 3; c++) begin
      if (m_valid_x && m_ready_x) xfers++;
      @(negedge clk);
    end
    check("t4_xfers", xfers, 3);
    reset = 1'b1;
    m_ready_x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t4_vx", m_valid_x, 0);
    check("t4_vf", m_valid_f, 0);
    check("t4_ry", s_ready_y, 0);
    check("t4_busy", busy, 0);
    check("t4_dx", m_data_x, 0);
    for (int c = 0; c < 4; c++) begin
      check("t4_nodone", done, 0);
      @(negedge clk);
    end
    run_loop("t4r", 0, -1);

    // 5: start and load pulsed mid-run are ignored
    run_loop("t5a", 0, 3);
    run_loop("t5b", 0, -1);
    for (int i = 0; i < NX; i++) xv[i] = i + 1;
    fv = '{1, 1, 1, 1};
    load_vectors(xv, fv);
    check("ref_y4", conv_ref(4), 26);
    run_loop("t5c", 0, -1);

    // random vectors
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NX; i++) xv[i] = $signed($urandom_range(0, 255)) - 128;
      for (int i = 0; i < NF; i++) fv[i] = $signed($urandom_range(0, 255)) - 128;
      load_vectors(xv, fv);
      run_loop($sformatf("rnd%0d", r), (r == 1) ? 5 : 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
